// File: rtl/port_arbiter_pkg.sv
// rtl/port_arbiter_pkg.sv - shared router constants, flit type codes and arbiter state encoding
package port_arbiter_pkg;

    localparam int PORT      = 4;
    localparam int DATAW     = 65;
    localparam int TYPEW_DEF = DATAW - 63;

    localparam logic [TYPEW_DEF-1:0] TYPE_NONE = TYPEW_DEF'(0);
    localparam logic [TYPEW_DEF-1:0] TYPE_HEAD = TYPEW_DEF'(1);
    localparam logic [TYPEW_DEF-1:0] TYPE_DATA = TYPEW_DEF'(2);
    localparam logic [TYPEW_DEF-1:0] TYPE_TAIL = TYPEW_DEF'(3);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/port_arbiter_if.sv
// rtl/port_arbiter_if.sv - per-output arbiter bus: input flit status in, mux select and pops out
interface port_arbiter_if #(
    parameter int NPORT = 5,
    parameter int TYPEW = 2
);
    logic [NPORT-1:0]       ivalid;
    logic [NPORT*TYPEW-1:0] itype;
    logic                   ordy;
    logic [NPORT-1:0]       sel;
    logic [NPORT-1:0]       oack;
    logic                   busy;
    logic                   wd_err;

    modport master (input ivalid, itype, ordy, output sel, oack, busy, wd_err);
    modport slave  (output ivalid, itype, ordy, input sel, oack, busy, wd_err);
endinterface

// File: rtl/port_arbiter_rr_pick.sv
// rtl/port_arbiter_rr_pick.sv - combinational round-robin pick: first requester at or above ptr, wrapping
module rr_pick #(
    parameter int  NPORT = 5,
    localparam int PW    = (NPORT > 1) ? $clog2(NPORT) : 1
) (
    input  logic [NPORT-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [NPORT-1:0] grant,
    output logic             valid
);

    logic [PW-1:0] idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = ptr;
        for (int i = 0; i < NPORT; i++) begin
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
            idx = (idx == PW'(NPORT - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/port_arbiter.sv
// rtl/port_arbiter.sv - packet-locked round-robin output arbiter; optional watchdog via PORT_ARBITER_WATCHDOG_EN
module port_arbiter
    import port_arbiter_pkg::*;
#(
    parameter int NPORT   = PORT + 1,
    parameter int TYPEW   = DATAW - 63,
    parameter int TIMEOUT = 16
) (
    input logic             clk,
    input logic             rst,
    port_arbiter_if.master  arb
);

    localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam logic [TYPEW-1:0] T_HEAD = TYPEW'(TYPE_HEAD);
    localparam logic [TYPEW-1:0] T_TAIL = TYPEW'(TYPE_TAIL);

    arb_state_e       state_q, state_d;
    logic [NPORT-1:0] sel_q, sel_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic             busy_q, busy_d;
    logic             wd_err_q, wd_err_d;

    logic [NPORT-1:0] req, pick_grant, oack_w;
    logic             pick_valid;
    logic [PW-1:0]    gidx;
    logic [TYPEW-1:0] gtype;
    logic             grant_go, tail_acc, wd_fire, release_lock;

    rr_pick #(.NPORT(NPORT)) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .valid (pick_valid)
    );

    // The pop is suppressed in a reset cycle so no flit is lost while the lock drops.
    assign oack_w   = rst ? '0 : (sel_q & arb.ivalid & {NPORT{arb.ordy}});
    assign arb.oack = oack_w;
    assign arb.sel  = sel_q;
    assign arb.busy = busy_q;
    assign arb.wd_err = wd_err_q;

    always_comb begin
        req   = '0;
        gidx  = '0;
        gtype = '0;
        for (int i = 0; i < NPORT; i++) begin
            req[i] = arb.ivalid[i] && (arb.itype[i*TYPEW +: TYPEW] == T_HEAD);
            if (sel_q[i]) begin
                gidx  = PW'(i);
                gtype = arb.itype[i*TYPEW +: TYPEW];
            end
        end
    end

    assign grant_go     = (state_q == ST_IDLE) && arb.ordy && pick_valid;
    assign tail_acc     = (state_q == ST_LOCKED) && (|oack_w) && (gtype == T_TAIL);
    assign release_lock = tail_acc || wd_fire;

`ifdef PORT_ARBITER_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wd_cnt_q, wd_cnt_d;
    logic          gvalid;

    assign gvalid = |(sel_q & arb.ivalid);

    // Counts starved cycles on the granted port; any accepted flit restarts the count.
    always_comb begin
        wd_cnt_d = wd_cnt_q;
        wd_fire  = 1'b0;
        if (state_q != ST_LOCKED || (|oack_w)) begin
            wd_cnt_d = '0;
        end else if (!gvalid) begin
            if (wd_cnt_q == CW'(TIMEOUT - 1)) begin
                wd_fire  = 1'b1;
                wd_cnt_d = '0;
            end else begin
                wd_cnt_d = wd_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) wd_cnt_q <= '0;
        else     wd_cnt_q <= wd_cnt_d;
    end
`else
    assign wd_fire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (grant_go)     state_d = ST_LOCKED;
            ST_LOCKED: if (release_lock) state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sel_d    = sel_q;
        busy_d   = busy_q;
        ptr_d    = ptr_q;
        wd_err_d = wd_fire;
        if (grant_go) begin
            sel_d  = pick_grant;
            busy_d = 1'b1;
        end else if (release_lock) begin
            sel_d  = '0;
            busy_d = 1'b0;
            ptr_d  = (gidx == PW'(NPORT - 1)) ? '0 : gidx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            ptr_q    <= '0;
            busy_q   <= 1'b0;
            wd_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            ptr_q    <= ptr_d;
            busy_q   <= busy_d;
            wd_err_q <= wd_err_d;
        end
    end

endmodule

// File: doc/port_arbiter.md
# port_arbiter

Per-output-port packet arbiter for the 5-port NoC router. It sits directly upstream of the output `mux` and drives its one-hot `sel`. It picks one input port per packet with round-robin fairness and holds that grant from the head flit through the tail flit. It also issues the per-input acknowledge that pops the winning input buffer.

## Interface
Parameters:
- `NPORT`, default 5: number of input ports; equals `` `PORT``+1.
- `TYPEW`, default `` `DATAW``−63: width of the flit type field, `idata[`DATAW:64]`.
- `TIMEOUT`, default 16: watchdog limit in cycles; used only with the watchdog macro.

Ports:
- `clk`, in, 1: clock; all logic on the rising edge.
- `rst`, in, 1: reset; synchronous, active-high.
- `ivalid`, in, NPORT: per-input flit valid; bit n comes from input n.
- `itype`, in, NPORT*TYPEW: per-input flit type; slice n is `itype[n*TYPEW +: TYPEW]`, using the `` `TYPE_*`` codes.
- `ordy`, in, 1: downstream (output link or VC buffer) can take a flit this cycle.
- `sel`, out, NPORT: registered one-hot select to `mux.sel`; all-zero when idle.
- `oack`, out, NPORT: combinational one-hot pop to the inputs, equal to `sel & ivalid & {NPORT{ordy}}`.
- `busy`, out, 1: registered; high while a packet holds the output.
- `wd_err`, out, 1: registered one-cycle pulse on a watchdog release; constant 0 without the macro.

## Operation
- Two states: IDLE and LOCKED.
- IDLE:
  - Request vector: `req[n] = ivalid[n] && itype_n == `TYPE_HEAD`. Non-head flits are ignored.
  - If `req` is non-zero, the round-robin pick starts at `ptr` and searches upward, wrapping from NPORT−1 to 0. The first requester wins.
  - On a win: `sel` loads the one-hot winner, `busy` goes to 1, and the state moves to LOCKED.
- LOCKED:
  - `sel` is held.
  - A flit on the granted port is accepted when `oack` of that port is 1.
  - When the accepted flit is `` `TYPE_TAIL``: `sel` goes to 0, `busy` goes to 0, `ptr` becomes (granted index + 1) mod NPORT, and the state returns to IDLE.
  - Requests on other ports have no effect while LOCKED.
- `ordy` = 0 stalls the block: `oack` = 0 and the state, `sel` and `ptr` are held.
- A grant is never revoked mid-packet, except by reset or the watchdog.
- Reset, including reset in mid-packet, forces: state IDLE, `sel` = 0, `busy` = 0, `ptr` = 0, `wd_err` = 0, watchdog counter = 0. The lock is dropped and no flit is acknowledged in a reset cycle.

## Timing
- Head-to-grant latency is 1 cycle. A head is seen valid in cycle t, `sel` is valid at t+1, and the head is acknowledged at t+1 if `ordy` = 1.
- `oack` is combinational in the same cycle as `ivalid` and `ordy`. The input buffer pops on that edge.
- The tail is accepted at cycle t and `sel` becomes 0 at t+1. The earliest next grant has `sel` valid at t+2, so there is one bubble cycle between packets.
- A tail accepted in the same cycle as a new head on another port: that head is arbitrated in the next IDLE cycle, using the updated `ptr`.
- Body flits arriving on the granted port with `ivalid` = 0 gaps are tolerated. The lock is held indefinitely unless the watchdog is enabled.

## Configuration
- `PORT_ARBITER_WATCHDOG_EN` defined:
  - In LOCKED, a counter increments every cycle in which the granted `ivalid` is 0.
  - It clears on any accepted flit and on entry to LOCKED.
  - When the counter reaches `TIMEOUT`, the block releases as if a tail had been accepted (`sel` = 0, `ptr` advanced, state IDLE) and `wd_err` pulses 1 for one cycle.
- Undefined: no counter is built, `wd_err` is tied to 0, and the lock is released only by a tail or by reset.

## Structure
- Shared package / `define.v` holds:
  - `` `TYPE_NONE``, `` `TYPE_HEAD``, `` `TYPE_DATA``, `` `TYPE_TAIL``, `` `PORT``, `` `DATAW``;
  - the IDLE and LOCKED state encodings.
- One sub-module: `rr_pick`, a combinational round-robin priority selector. It takes `req[NPORT]` and `ptr` and returns a one-hot grant plus a valid bit, and is reused by other allocators.

## Test plan
- Reset, then a head on port 1 only with `ordy` = 1:
  - `sel` = 00010 one cycle later;
  - then 20 DATA flits and one TAIL, each acknowledged;
  - `sel` = 0 the cycle after the tail; `ptr` = 2.
- Heads on ports 0, 1 and 3 together, `ptr` = 0, each packet 3 flits long:
  - grants go 0 → 1 → 3;
  - there is exactly one idle cycle between grants.
- `ordy` held 0 for 4 cycles mid-packet:
  - `oack` = 0 throughout;
  - `sel` is unchanged;
  - the flit is acknowledged on the first cycle `ordy` = 1.
- A DATA flit on port 2 while IDLE: no grant is made and `sel` stays 0.
- Assert `rst` mid-packet while port 4 is locked: next cycle `sel` = 0, `busy` = 0, `ptr` = 0.
- Watchdog, with the macro defined and `TIMEOUT` = 16:
  - Port 0 is locked, then `ivalid[0]` is held 0 for 16 cycles.
  - `wd_err` pulses once, `sel` = 0 and `ptr` = 1.
  - Without the macro, the lock persists.
